// File: rtl/snap_mem_arbiter.sv
// rtl/snap_mem_arbiter.sv - CPU / loader arbiter for the shared external RAM port
// Optional grant and fill statistics are enabled with SNAP_ARB_STATS_EN.
module snap_mem_arbiter #(
    parameter int FIFO_DEPTH  = 8,
    parameter int BUSY_MARGIN = 2,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        ldr_wr,
    input  logic [24:0] ldr_addr,
    input  logic [7:0]  ldr_data,
    output logic        ldr_busy,
    output logic        ldr_idle,
    output logic        ldr_ovf,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [24:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [24:0] ram_addr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic        ram_we,
    output logic        ram_rd,
    input  logic        ram_busy
`ifdef SNAP_ARB_STATS_EN
    ,
    output logic [15:0] stat_cpu_grants,
    output logic [15:0] stat_ldr_grants,
    output logic [$clog2(FIFO_DEPTH):0] stat_max_fill
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = $clog2(MAX_CPU_RUN + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    logic [32:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic          ovf_q, ovf_d, busy_q, busy_d;
    state_t        state_q, state_d;
    logic          gnt_ldr_q, gnt_ldr_d, wait_first_q, wait_first_d;
    logic [RW-1:0] cpu_run_q, cpu_run_d;
    logic [24:0]   ram_addr_q, ram_addr_d;
    logic [7:0]    ram_dout_q, ram_dout_d, cpu_din_q, cpu_din_d;
    logic          ram_we_q, ram_we_d, ram_rd_q, ram_rd_d, cpu_ack_q, cpu_ack_d;
    logic          fifo_empty, fifo_full, push, pop;
    logic [32:0]   head;

    assign fifo_empty = (fill_q == '0);
    assign fifo_full  = (fill_q == (AW+1)'(FIFO_DEPTH));
    assign push       = ldr_wr && !fifo_full;
    assign pop        = (state_q == ISSUE) && gnt_ldr_q;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d     = wr_ptr_q + AW'(push);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        fill_d       = fill_q;
        ovf_d        = ovf_q | (ldr_wr && fifo_full);
        busy_d       = (fill_q >= (AW+1)'(FIFO_DEPTH - BUSY_MARGIN));
        state_d      = state_q;
        gnt_ldr_d    = gnt_ldr_q;
        wait_first_d = wait_first_q;
        cpu_run_d    = fifo_empty ? '0 : cpu_run_q;
        ram_addr_d   = ram_addr_q;
        ram_dout_d   = ram_dout_q;
        ram_we_d     = 1'b0;
        ram_rd_d     = 1'b0;
        cpu_ack_d    = 1'b0;
        cpu_din_d    = cpu_din_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
        case (state_q)
            IDLE: begin
                // The ack cycle still sees cpu_req high; skip it so one request is not served twice.
                if (!ram_busy && !cpu_ack_q && (cpu_req || !fifo_empty)) begin
                    state_d = ISSUE;
                    if (!fifo_empty && (!cpu_req || cpu_run_q == RW'(MAX_CPU_RUN))) begin
                        gnt_ldr_d  = 1'b1;
                        cpu_run_d  = '0;
                        ram_addr_d = head[32:8];
                        ram_dout_d = head[7:0];
                        ram_we_d   = 1'b1;
                    end else begin
                        gnt_ldr_d  = 1'b0;
                        if (!fifo_empty && cpu_run_q != RW'(MAX_CPU_RUN))
                            cpu_run_d = cpu_run_q + 1'b1;
                        ram_addr_d = cpu_addr;
                        ram_dout_d = cpu_dout;
                        ram_we_d   = cpu_we;
                        ram_rd_d   = !cpu_we;
                    end
                end
            end
            ISSUE: begin
                state_d      = WAIT;
                wait_first_d = 1'b1;
            end
            WAIT: begin
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (!ram_busy) begin
                    state_d = IDLE;
                    if (!gnt_ldr_q) begin
                        cpu_ack_d = 1'b1;
                        if (!cpu_we)
                            cpu_din_d = ram_din;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push)
            mem_q[wr_ptr_q] <= {ldr_addr, ldr_data};
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
            gnt_ldr_q    <= 1'b0;
            wait_first_q <= 1'b0;
            cpu_run_q    <= '0;
            ram_addr_q   <= '0;
            ram_dout_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_rd_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_din_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
            state_q      <= state_d;
            gnt_ldr_q    <= gnt_ldr_d;
            wait_first_q <= wait_first_d;
            cpu_run_q    <= cpu_run_d;
            ram_addr_q   <= ram_addr_d;
            ram_dout_q   <= ram_dout_d;
            ram_we_q     <= ram_we_d;
            ram_rd_q     <= ram_rd_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_din_q    <= cpu_din_d;
        end
    end

    assign ldr_busy = busy_q;
    assign ldr_ovf  = ovf_q;
    assign ldr_idle = fifo_empty && !(state_q != IDLE && gnt_ldr_q);
    assign cpu_din  = cpu_din_q;
    assign cpu_ack  = cpu_ack_q;
    assign ram_addr = ram_addr_q;
    assign ram_dout = ram_dout_q;
    assign ram_we   = ram_we_q;
    assign ram_rd   = ram_rd_q;

`ifdef SNAP_ARB_STATS_EN
    logic [15:0] stat_cpu_q, stat_cpu_d, stat_ldr_q, stat_ldr_d;
    logic [AW:0] max_fill_q, max_fill_d;

    always_comb begin
        stat_cpu_d = stat_cpu_q;
        stat_ldr_d = stat_ldr_q;
        max_fill_d = (fill_q > max_fill_q) ? fill_q : max_fill_q;
        if (state_q == ISSUE && !gnt_ldr_q && stat_cpu_q != 16'hFFFF)
            stat_cpu_d = stat_cpu_q + 1'b1;
        if (state_q == ISSUE && gnt_ldr_q && stat_ldr_q != 16'hFFFF)
            stat_ldr_d = stat_ldr_q + 1'b1;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            stat_cpu_q <= '0;
            stat_ldr_q <= '0;
            max_fill_q <= '0;
        end else begin
            stat_cpu_q <= stat_cpu_d;
            stat_ldr_q <= stat_ldr_d;
            max_fill_q <= max_fill_d;
        end
    end

    assign stat_cpu_grants = stat_cpu_q;
    assign stat_ldr_grants = stat_ldr_q;
    assign stat_max_fill   = max_fill_q;
`endif
endmodule

// File: doc/snap_mem_arbiter.md
Name: snap_mem_arbiter

Overview:
- Shares the single external RAM port between the Z80 CPU memory path and the snapshot/tape loader write stream.
- Loader writes arrive as one-cycle strobes. They are buffered in a small FIFO, and back-pressure is raised early enough for the loader to stall its download (ioctl_wait).
- The CPU normally has priority. A starvation limit guarantees loader progress.
- The block sits between the loader, the CPU bus adapter and the SDRAM controller.

Parameters:
- FIFO_DEPTH, 8: loader write FIFO entries; power of two, ≥4.
- BUSY_MARGIN, 2: ldr_busy asserts when fill ≥ FIFO_DEPTH − BUSY_MARGIN.
- MAX_CPU_RUN, 4: consecutive CPU grants allowed while the FIFO is non-empty before one forced loader grant.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ldr_wr  in  1  loader write strobe; one cycle per byte.
- ldr_addr  in  25  loader byte address.
- ldr_data  in  8  loader write data.
- ldr_busy  out  1  back-pressure to the loader; drives ioctl_wait.
- ldr_idle  out  1  FIFO empty, and no loader transfer in flight.
- ldr_ovf  out  1  sticky flag: a write arrived while the FIFO was full.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  25  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_din  out  8  CPU read data; valid in the cpu_ack cycle.
- cpu_ack  out  1  one-cycle completion pulse.
- ram_addr  out  25  RAM address.
- ram_dout  out  8  RAM write data.
- ram_din  in  8  RAM read data.
- ram_we  out  1  one-cycle write command.
- ram_rd  out  1  one-cycle read command.
- ram_busy  in  1  RAM controller busy; must go high the cycle after a command and low when the access is done.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO emptied, pointers and fill cleared.
  - FSM goes to IDLE; cpu_run = 0.
  - All outputs 0, except ldr_idle = 1.
  - ldr_ovf is cleared only by reset.
- FIFO:
  - Each ldr_wr pushes {addr, data}. A push and a pop in the same cycle leaves fill unchanged.
  - A push when full is dropped and sets ldr_ovf; the FIFO contents are not disturbed.
  - Pointers wrap modulo FIFO_DEPTH.
  - ldr_busy is registered: ldr_busy = (fill ≥ FIFO_DEPTH − BUSY_MARGIN), updated one cycle after the fill change.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if ram_busy = 0 and a requester is pending, select a grant and go to ISSUE. Otherwise stay.
  - Grant order: cpu_req wins unless (FIFO non-empty and cpu_run == MAX_CPU_RUN), in which case the loader wins. The loader is granted when cpu_req = 0 and the FIFO is non-empty.
  - cpu_run: +1 per CPU grant while the FIFO is non-empty; reset to 0 on a loader grant or when the FIFO is empty; saturates at MAX_CPU_RUN.
  - ISSUE (1 cycle): drive ram_addr/ram_dout and pulse ram_we or ram_rd. A loader grant pops the FIFO head in this cycle. Go to WAIT.
  - WAIT: first cycle is unconditional. Afterwards, when ram_busy = 0:
    - CPU grant: capture ram_din into cpu_din (for reads), pulse cpu_ack, then go to IDLE.
    - Loader grant: go to IDLE.
- Latency: with idle RAM and a 1-cycle busy, a CPU access takes cpu_req→ISSUE 1 cycle, cpu_ack at cycle 4 minimum.
- cpu_req dropping before cpu_ack is illegal; behaviour is unspecified.
- ram_addr and ram_dout hold their last value outside ISSUE. ram_we and ram_rd are never high together.
- ldr_idle = (fill == 0) and not (state ≠ IDLE with a loader grant).

Optional Feature:
- SNAP_ARB_STATS_EN defined:
  - Adds outputs stat_cpu_grants[15:0] and stat_ldr_grants[15:0], saturating counters cleared by reset.
  - Adds stat_max_fill[$clog2(FIFO_DEPTH):0], the peak fill level seen.
- SNAP_ARB_STATS_EN undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-transfer:
  - Stimulus: assert rst_n low during WAIT with 3 FIFO entries queued.
  - Required: all outputs 0 and ldr_idle = 1 immediately; no ram_we after release.
- Loader burst:
  - Stimulus: 8 back-to-back ldr_wr, addr 0x4000–0x4007, data 0xA0–0xA7; cpu_req low; ram_busy one cycle per access.
  - Required: ldr_busy high after fill reaches 6; 8 ram_we pulses in order with matching addr/data; ldr_ovf = 0; ldr_idle returns to 1.
- Overflow:
  - Stimulus: 9 writes with ram_busy held high.
  - Required: 9th write dropped; ldr_ovf = 1 and stays 1; first 8 entries are written once busy releases.
- CPU read:
  - Stimulus: cpu_req=1, cpu_we=0, addr 0x00005C00; RAM returns 0x3C.
  - Required: exactly one ram_rd; cpu_ack pulse with cpu_din = 0x3C.
- Starvation:
  - Stimulus: cpu_req held continuously with 4 FIFO entries queued, MAX_CPU_RUN = 4.
  - Required: grant sequence CPU×4, LDR, CPU×4, LDR, …
- Simultaneous push and pop:
  - Stimulus: ldr_wr in the ISSUE cycle of a loader grant at fill 5.
  - Required: fill stays 5; ldr_busy unchanged.
